// File: rtl/vram_fill_ctrl_if.sv
// rtl/vram_fill_ctrl_if.sv - CPU write, config/status and VRAM port A signal bundle for vram_fill_ctrl
interface vram_fill_ctrl_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8
);
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_data;
   logic              cfg_we;
   logic [1:0]        cfg_sel;
   logic [31:0]       cfg_data;
   logic [31:0]       status;
   logic              vram_we;
   logic [ADDR_W-1:0] vram_addr;
   logic [DATA_W-1:0] vram_din;
   logic              busy;
   logic              done;

   modport master (
      output cpu_we, cpu_addr, cpu_data, cfg_we, cfg_sel, cfg_data,
      input  status, vram_we, vram_addr, vram_din, busy, done
   );

   modport slave (
      input  cpu_we, cpu_addr, cpu_data, cfg_we, cfg_sel, cfg_data,
      output status, vram_we, vram_addr, vram_din, busy, done
   );
endinterface

// File: rtl/vram_fill_ctrl.sv
// rtl/vram_fill_ctrl.sv - VRAM port A arbiter between CPU writes and a constant-colour fill engine
module vram_fill_ctrl #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input logic              clk,
   input logic              rst,
   vram_fill_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  count_q;
   logic [DATA_W-1:0] color_q;
   logic [ADDR_W-1:0] cur_addr;
   logic [CNT_W-1:0]  remaining;
   logic              done_sticky;
   logic              aborted;
   logic              vram_we_q;
   logic [ADDR_W-1:0] vram_addr_q;
   logic [DATA_W-1:0] vram_din_q;
   logic              busy_q;
   logic              done_q;

   logic              base_wr;
   logic              count_wr;
   logic              ctrl_wr;
   logic              go;
   logic              abort;
   logic              start;
   logic              clear_flags;
   logic              eng_issue;
   logic              unused_cfg;

   assign base_wr  = bus.cfg_we && (bus.cfg_sel == 2'd0);
   assign count_wr = bus.cfg_we && (bus.cfg_sel == 2'd1);
   assign ctrl_wr  = bus.cfg_we && (bus.cfg_sel == 2'd2);
   assign go       = ctrl_wr && bus.cfg_data[0];
   assign abort    = ctrl_wr && bus.cfg_data[1];

   assign unused_cfg = ^bus.cfg_data[31:16];

   // The CPU always owns the port when it writes; the engine only issues on idle bus cycles.
   always_comb begin
      state_d     = state_q;
      start       = 1'b0;
      clear_flags = 1'b0;
      eng_issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (go) begin
               clear_flags = 1'b1;
               if (count_q != '0) begin
                  start   = 1'b1;
                  state_d = FILL;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FILL: begin
            if (abort) begin
               state_d = IDLE;
            end else if (!bus.cpu_we) begin
               eng_issue = 1'b1;
               if (remaining == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == FILL);
         done_q  <= (state_d == DONE);
      end
   end

   // Configuration is frozen while a fill is running so the run stays self-consistent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q  <= '0;
         count_q <= '0;
         color_q <= '0;
      end else if (state_q != FILL) begin
         if (base_wr) begin
            base_q <= bus.cfg_data[ADDR_W-1:0];
         end
         if (count_wr) begin
            count_q <= bus.cfg_data[CNT_W-1:0];
         end
         if (ctrl_wr) begin
            color_q <= bus.cfg_data[15:8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_addr  <= '0;
         remaining <= '0;
      end else if (start) begin
         cur_addr  <= base_q;
         remaining <= count_q;
      end else if (eng_issue) begin
         cur_addr  <= cur_addr + ADDR_W'(1);
         remaining <= remaining - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_sticky <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         if (clear_flags) begin
            done_sticky <= 1'b0;
            aborted     <= 1'b0;
         end
         if ((state_q == FILL) && abort) begin
            aborted <= 1'b1;
         end
         if (state_q == DONE) begin
            done_sticky <= 1'b1;
         end
      end
   end

   // Single registered write stage shared by both requesters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vram_we_q   <= 1'b0;
         vram_addr_q <= '0;
         vram_din_q  <= '0;
      end else begin
         vram_we_q <= bus.cpu_we || eng_issue;
         if (bus.cpu_we) begin
            vram_addr_q <= bus.cpu_addr;
            vram_din_q  <= bus.cpu_data;
         end else if (eng_issue) begin
            vram_addr_q <= cur_addr;
            vram_din_q  <= color_q;
         end
      end
   end

   assign bus.vram_we   = vram_we_q;
   assign bus.vram_addr = vram_addr_q;
   assign bus.vram_din  = vram_din_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.status    = {busy_q, done_sticky, aborted, {(29 - CNT_W){1'b0}}, remaining};

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// tb/tb_vram_fill_ctrl.sv - self-checking bench for vram_fill_ctrl against a write-stream reference model
module tb_vram_fill_ctrl;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 8;

   typedef struct {
      int                c;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   wr_t  wq[$];

   vram_fill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   vram_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Observed write stream, time-stamped by cycle.
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (bus.vram_we === 1'b1) wq.push_back('{cyc, bus.vram_addr, bus.vram_din});
      if (bus.done === 1'b1) done_cnt = done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
      bus.cfg_we   = 1'b1;
      bus.cfg_sel  = sel;
      bus.cfg_data = data;
      @(negedge clk);
      bus.cfg_we   = 1'b0;
   endtask

   // Expected stream: every CPU write one cycle after issue; engine fills base+i in order, one per non-stalled cycle.
   task automatic run_fill(input logic [ADDR_W-1:0] base, input int count, input logic [7:0] color,
                           input bit wr_base, input logic [63:0] mask, input int pct);
      int                p, k, entry, stalls, e;
      bit                seen;
      wr_t               w;
      wr_t               cl[$];
      logic [ADDR_W-1:0] ca;
      logic [DATA_W-1:0] cd;
      logic [ADDR_W-1:0] ea;
      if (wr_base) cfg_write(2'd0, 32'(base));
      cfg_write(2'd1, 32'(count));
      p = wq.size();
      k = done_cnt;
      cfg_write(2'd2, {16'h0, color, 8'h01});
      entry  = cyc;
      stalls = 0;
      seen   = 1'b0;
      for (int idx = 1; idx <= 2000; idx++) begin
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy && (((idx < 64) && mask[idx]) || ($urandom_range(0, 99) < pct))) begin
            if ((idx < 64) && mask[idx]) begin
               ca = 15'h1234;
               cd = 8'h55;
            end else begin
               ca = 15'($urandom);
               cd = 8'($urandom);
            end
            bus.cpu_we   = 1'b1;
            bus.cpu_addr = ca;
            bus.cpu_data = cd;
            cl.push_back('{cyc + 1, ca, cd});
            stalls++;
         end else begin
            bus.cpu_we = 1'b0;
         end
         @(negedge clk);
      end
      bus.cpu_we = 1'b0;
      chk("fill_done_seen", 64'(seen), 64'd1);
      chk("fill_done_latency", 64'(cyc - entry), 64'(count + stalls));
      @(negedge clk);
      chk("done_single_cycle", 64'(bus.done), 64'd0);
      chk("status_after_fill", 64'(bus.status), 64'h4000_0000);
      chk("done_pulses", 64'(done_cnt - k), 64'd1);
      e = 0;
      for (int i = p; i < wq.size(); i++) begin
         w = wq[i];
         if ((cl.size() > 0) && (cl[0].c == w.c)) begin
            chk("cpu_addr", 64'(w.a), 64'(cl[0].a));
            chk("cpu_data", 64'(w.d), 64'(cl[0].d));
            void'(cl.pop_front());
         end else begin
            ea = base + ADDR_W'(e);
            chk("eng_in_range", 64'(e < count), 64'd1);
            chk("eng_addr", 64'(w.a), 64'(ea));
            chk("eng_data", 64'(w.d), 64'(color));
            e++;
         end
      end
      chk("eng_write_count", 64'(e), 64'(count));
      chk("cpu_writes_lost", 64'(cl.size()), 64'd0);
   endtask

   initial begin
      int p, k;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = '0;
      bus.cpu_data = '0;
      bus.cfg_we   = 1'b0;
      bus.cfg_sel  = '0;
      bus.cfg_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_status", 64'(bus.status), 64'd0);
      chk("rst_vram_we", 64'(bus.vram_we), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // CPU write in IDLE together with a BASE write; both must land.
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = 15'h1111;
      bus.cpu_data = 8'h22;
      cfg_write(2'd0, 32'h0000_0100);
      bus.cpu_we = 1'b0;
      chk("idle_cpu_we", 64'(bus.vram_we), 64'd1);
      chk("idle_cpu_addr", 64'(bus.vram_addr), 64'h1111);
      chk("idle_cpu_data", 64'(bus.vram_din), 64'h22);
      @(negedge clk);
      chk("idle_we_drop", 64'(bus.vram_we), 64'd0);

      run_fill(15'h0100, 4, 8'hAB, 1'b0, 64'd0, 0);
      run_fill(15'h7FFE, 3, 8'h3C, 1'b1, 64'd0, 0);
      run_fill(15'h0200, 8, 8'hC3, 1'b1, 64'h0000_0000_0000_000C, 0);
      run_fill(15'h0400, 0, 8'h11, 1'b1, 64'd0, 0);

      // Abort after ten engine writes; a BASE write mid-fill must not stick.
      cfg_write(2'd0, 32'h0000_0300);
      cfg_write(2'd1, 32'd100);
      p = wq.size();
      k = done_cnt;
      cfg_write(2'd2, 32'h0000_7701);
      chk("abort_busy_on", 64'(bus.busy), 64'd1);
      cfg_write(2'd0, 32'h0000_0ABC);
      repeat (9) @(negedge clk);
      cfg_write(2'd2, 32'h0000_0002);
      chk("abort_busy_off", 64'(bus.busy), 64'd0);
      chk("abort_status", 64'(bus.status), 64'h2000_005A);
      chk("abort_no_write", 64'(bus.vram_we), 64'd0);
      chk("abort_no_done", 64'(done_cnt - k), 64'd0);
      chk("abort_write_count", 64'(wq.size() - p), 64'd10);
      for (int i = 0; i < 10; i++) begin
         if (p + i < wq.size()) begin
            chk("abort_addr", 64'(wq[p + i].a), 64'(15'h0300 + 15'(i)));
            chk("abort_data", 64'(wq[p + i].d), 64'h77);
         end
      end
      run_fill(15'h0300, 2, 8'h5A, 1'b0, 64'd0, 0);

      for (int r = 0; r < 6; r++) begin
         run_fill(15'($urandom), int'($urandom_range(1, 40)), 8'($urandom), 1'b1, 64'd0, 30);
      end

      // Asynchronous reset in the middle of a fill.
      cfg_write(2'd0, 32'h0000_0010);
      cfg_write(2'd1, 32'd50);
      cfg_write(2'd2, 32'h0000_9901);
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_mid_vram_we", 64'(bus.vram_we), 64'd0);
      chk("rst_mid_busy", 64'(bus.busy), 64'd0);
      chk("rst_mid_status", 64'(bus.status), 64'd0);
      chk("rst_mid_done", 64'(bus.done), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      p = wq.size();
      repeat (20) @(negedge clk);
      chk("post_rst_writes", 64'(wq.size() - p), 64'd0);
      chk("post_rst_busy", 64'(bus.busy), 64'd0);
      chk("post_rst_status", 64'(bus.status), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
